// File: rtl/sigmoid_lut_arbiter_if.sv
// Requester / LUT / result-consumer bundle for sigmoid_lut_arbiter.
// The slave modport is the arbiter; the master modport is its surroundings (requesters, LUT, consumer).
interface sigmoid_lut_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int OPW       = 10,
  parameter int inWidth   = 10,
  parameter int dataWidth = 16
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*OPW-1:0] req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic [inWidth-1:0]     lut_num;
  logic [dataWidth-1:0]   lut_out;
  logic                   res_valid;
  logic                   res_ready;
  logic [IDW-1:0]         res_id;
  logic [dataWidth-1:0]   res_data;
  logic                   busy;

  modport master (
    output req_valid, req_data, lut_out, res_ready,
    input  req_ready, lut_num, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  req_valid, req_data, lut_out, res_ready,
    output req_ready, lut_num, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/sigmoid_lut_arbiter.sv
// Round-robin share of one 1-cycle sigmoid LUT; grant in cycle t gives res_valid at t+2, results queued 2 deep.
// Grants stall while queue + in-flight read would overflow; define SIGARB_SAT_EN for saturating sumWidth operands.
module sigmoid_lut_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int inWidth   = 10,
  parameter int dataWidth = 16,
  parameter int sumWidth  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sigmoid_lut_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
`ifdef SIGARB_SAT_EN
  localparam int OPW = sumWidth;
`else
  localparam int OPW = inWidth;
`endif

  if (sumWidth < inWidth) begin : g_bad_width
    $error("sumWidth must be >= inWidth");
  end

  logic                 run_q;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d, id_pipe_q;
  logic                 head_q, tail;
  logic [IDW-1:0]       q_id_q   [2];
  logic [dataWidth-1:0] q_data_q [2];

  logic                 pop, push, can_issue, gnt_vld;
  logic [2:0]           pending;
  logic [IDW-1:0]       gnt_idx, cand;
  logic [OPW-1:0]       op;
  logic [inWidth-1:0]   op_lut;

  assign pop       = bus.res_valid & bus.res_ready;
  assign push      = inflight_q;
  assign pending   = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  // run_q keeps req_ready low while reset is held and for the first edge after release
  assign can_issue = run_q && (pending < 3'd2);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_vld && bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!can_issue) gnt_vld = 1'b0;
  end

  assign op = bus.req_data[int'(gnt_idx)*OPW +: OPW];

`ifdef SIGARB_SAT_EN
  localparam logic signed [OPW-1:0] SAT_MAX = OPW'((1 << (inWidth - 1)) - 1);
  localparam logic signed [OPW-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    op_lut = op[inWidth-1:0];
    if ($signed(op) > SAT_MAX)      op_lut = SAT_MAX[inWidth-1:0];
    else if ($signed(op) < SAT_MIN) op_lut = SAT_MIN[inWidth-1:0];
  end
`else
  assign op_lut = op;
`endif

  assign bus.req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign bus.lut_num   = gnt_vld ? op_lut : '0;

  assign rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  assign occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
  assign tail     = head_q ^ occ_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      rr_ptr_q    <= '0;
      id_pipe_q   <= '0;
      head_q      <= 1'b0;
      q_id_q[0]   <= '0;
      q_id_q[1]   <= '0;
      q_data_q[0] <= '0;
      q_data_q[1] <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= gnt_vld;
      occ_q      <= occ_d;
      if (gnt_vld) begin
        rr_ptr_q  <= rr_ptr_d;
        id_pipe_q <= gnt_idx;
      end
      // LUT data for last cycle's grant is valid now; capture with its requester id
      if (push) begin
        q_id_q[tail]   <= id_pipe_q;
        q_data_q[tail] <= bus.lut_out;
      end
      if (pop) head_q <= ~head_q;
    end
  end

  assign bus.res_valid = (occ_q != 2'd0);
  assign bus.res_id    = q_id_q[head_q];
  assign bus.res_data  = q_data_q[head_q];
  assign bus.busy      = (occ_q != 2'd0) | inflight_q;
endmodule
